// File: rtl/msx50bus_initiator.sv
// msx50bus_initiator: host-side MSX-50BUS cycle generator.
// Turns a level-sensitive single-request command port into a slot-select plus
// read- or write-strobe bus cycle that advances on T-state ticks
// (mclk_pcen_n low). It honours the bus /WAIT line in T2 and at the end of
// the fixed wait states, and it captures read data in T3.
module msx50bus_initiator #(
  parameter int         WAIT_STATES = 1,     // fixed Tw states after T2 (0..7)
  parameter logic [7:0] FLOAT_DATA  = 8'hFF  // value read when nobody drives the bus
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        mclk_pcen_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        busy,
  output logic        done,
  output logic [7:0]  done_rdata,
  output logic        n_tsltsl,
  output logic        n_trd,
  output logic        n_twr,
  output logic [15:0] ta,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        rdata_en,
  input  logic        n_wait
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

  // The Tw counter is loaded with WAIT_STATES-1 on the way out of T2. It
  // clamps to 0 when no wait states are configured, because TW is then
  // never entered.
  localparam logic [2:0] TW_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t     state;
  logic [2:0] tw_cnt;
  logic       cyc_wr;
  logic       tick;

  assign tick = ~mclk_pcen_n;

  // Bus cycle sequencer. Every output is a register, and reset aborts any
  // cycle in progress without producing a done pulse.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      tw_cnt     <= 3'd0;
      cyc_wr     <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_rdata <= FLOAT_DATA;
      n_tsltsl   <= 1'b1;
      n_trd      <= 1'b1;
      n_twr      <= 1'b1;
      ta         <= 16'h0000;
      wdata      <= 8'h00;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        // Acceptance does not wait for a tick. ta and wdata are loaded here,
        // so they are already stable before any strobe goes low.
        S_IDLE: begin
          if (req) begin
            cyc_wr <= req_wr;
            ta     <= req_addr;
            wdata  <= req_wdata;
            ack    <= 1'b1;
            busy   <= 1'b1;
            state  <= S_T1;
          end
        end
        S_T1: begin
          if (tick) begin
            n_tsltsl <= 1'b0;
            n_trd    <= cyc_wr;
            n_twr    <= ~cyc_wr;
            state    <= S_T2;
          end
        end
        S_T2: begin
          if (tick && n_wait) begin
            if (WAIT_STATES > 0) begin
              tw_cnt <= TW_LOAD;
              state  <= S_TW;
            end else begin
              state  <= S_T3;
            end
          end
        end
        // The fixed wait states always elapse. /WAIT is only looked at on
        // the last one.
        S_TW: begin
          if (tick) begin
            if (tw_cnt != 3'd0)
              tw_cnt <= tw_cnt - 3'd1;
            else if (n_wait)
              state <= S_T3;
          end
        end
        // Read data is sampled on the same edge that releases the strobes.
        S_T3: begin
          if (tick) begin
            if (!cyc_wr)
              done_rdata <= rdata_en ? rdata : FLOAT_DATA;
            n_tsltsl <= 1'b1;
            n_trd    <= 1'b1;
            n_twr    <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msx50bus_initiator.sv
// tb_msx50bus_initiator: directed and randomized checks of the MSX-50BUS
// initiator against a tick-counting behavioural model of a bus cycle.
module tb_msx50bus_initiator;

  localparam int         WS  = 1;
  localparam logic [7:0] FLT = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset, mclk_pcen_n, req, req_wr, rdata_en, n_wait;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, rdata;
  logic        ack, busy, done, n_tsltsl, n_trd, n_twr;
  logic [7:0]  done_rdata, wdata;
  logic [15:0] ta;

  msx50bus_initiator #(.WAIT_STATES(WS), .FLOAT_DATA(FLT)) dut (
    .clk(clk), .n_reset(n_reset), .mclk_pcen_n(mclk_pcen_n),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .busy(busy), .done(done), .done_rdata(done_rdata),
    .n_tsltsl(n_tsltsl), .n_trd(n_trd), .n_twr(n_twr),
    .ta(ta), .wdata(wdata),
    .rdata(rdata), .rdata_en(rdata_en), .n_wait(n_wait)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // The model describes a bus cycle as a count of advancing ticks after
  // acceptance. Tick 1 drops the strobes. /WAIT can hold the position at
  // the T2 tick and at the last fixed wait tick. Tick 2+WS+1 releases the
  // strobes and ends the cycle.
  logic        m_ok = 1'b0;
  logic        m_busy, m_ack, m_done, m_sel, m_rdn, m_wrn, m_wr;
  logic [7:0]  m_rd, m_wd;
  logic [15:0] m_ta;
  int          m_pos;

  always @(posedge clk) begin
    m_ack  <= 1'b0;
    m_done <= 1'b0;
    if (!n_reset) begin
      m_ok <= 1'b1; m_busy <= 1'b0; m_sel <= 1'b1; m_rdn <= 1'b1; m_wrn <= 1'b1;
      m_ta <= '0; m_wd <= '0; m_rd <= FLT; m_pos <= 0; m_wr <= 1'b0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy <= 1'b1; m_ack <= 1'b1; m_wr <= req_wr;
        m_ta <= req_addr; m_wd <= req_wdata; m_pos <= 0;
      end
    end else if (!mclk_pcen_n) begin
      if (m_pos == 0) begin
        m_sel <= 1'b0;
        if (m_wr) m_wrn <= 1'b0; else m_rdn <= 1'b0;
        m_pos <= 1;
      end else if (m_pos == 2 + WS) begin
        if (!m_wr) m_rd <= rdata_en ? rdata : FLT;
        m_sel <= 1'b1; m_rdn <= 1'b1; m_wrn <= 1'b1;
        m_done <= 1'b1; m_busy <= 1'b0;
      end else if (!((m_pos == 1 || m_pos == 1 + WS) && !n_wait)) begin
        m_pos <= m_pos + 1;
      end
    end
  end

  // Compare process: every output against the model on each falling edge,
  // plus the bus invariants.
  logic        p_low = 1'b0;
  logic [15:0] p_ta  = '0;
  logic [7:0]  p_wd  = '0;
  always @(negedge clk) begin
    if (m_ok) begin
      check("outputs", 64'({ack, busy, done, done_rdata, n_tsltsl, n_trd, n_twr, ta, wdata}),
                       64'({m_ack, m_busy, m_done, m_rd, m_sel, m_rdn, m_wrn, m_ta, m_wd}));
      check("rd_wr_exclusive", 64'(n_trd | n_twr), 64'(1));
      if (p_low && !n_tsltsl) check("addr_data_stable", 64'({ta, wdata}), 64'({p_ta, p_wd}));
      p_low = ~n_tsltsl; p_ta = ta; p_wd = wdata;
    end
  end

  // Tick source: 0 = one tick every 6 clks, 1 = random, 2 = stuck high.
  int tick_mode = 0;
  initial begin
    int c = 0;
    mclk_pcen_n = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (tick_mode)
        0: begin c = (c + 1) % 6; mclk_pcen_n = (c != 0); end
        1: mclk_pcen_n = ($urandom_range(0, 2) != 0);
        default: mclk_pcen_n = 1'b1;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command and follow it to done. Returns the strobe length in
  // ticks and which of the two strobes went low.
  task automatic do_cycle(input logic wr, input logic [15:0] a, input logic [7:0] d,
                          output int ticks, output logic saw_rd, output logic saw_wr);
    logic seen = 1'b0;
    logic fin  = 1'b0;
    int   lat  = 0;
    @(negedge clk);
    req_wr = wr; req_addr = a; req_wdata = d; req = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); lat++;
      if (ack) seen = 1'b1;
    end
    req = 1'b0;
    check("ack_seen", 64'(seen), 64'(1));
    check("ack_latency", 64'(lat), 64'(1));
    ticks = 0; saw_rd = 1'b0; saw_wr = 1'b0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      if (!n_tsltsl && !mclk_pcen_n) ticks++;
      if (!n_trd) saw_rd = 1'b1;
      if (!n_twr) saw_wr = 1'b1;
      @(negedge clk);
      if (done) fin = 1'b1;
    end
    check("done_seen", 64'(fin), 64'(1));
  endtask

  initial begin
    int   t, g, acks, k;
    logic sr, sw, got;
    n_reset = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rdata = '0; rdata_en = 1'b0; n_wait = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_strobes", 64'({n_tsltsl, n_trd, n_twr}), 64'(3'b111));
    check("rst_ta", 64'(ta), 64'(0));
    check("rst_rdata", 64'(done_rdata), 64'(8'hFF));
    check("rst_busy", 64'({busy, ack, done}), 64'(0));
    n_reset = 1'b1;

    // Write cycle
    do_cycle(1'b1, 16'h9800, 8'h5A, t, sr, sw);
    check("wr_ticks", 64'(t), 64'(3));
    check("wr_bus", 64'({ta, wdata}), 64'({16'h9800, 8'h5A}));
    check("wr_strobes", 64'({sr, sw}), 64'(2'b01));
    check("wr_rdata_kept", 64'(done_rdata), 64'(8'hFF));

    // Read cycles, driven and floating
    rdata = 8'hA5; rdata_en = 1'b1;
    do_cycle(1'b0, 16'h9880, 8'h00, t, sr, sw);
    check("rd_ticks", 64'(t), 64'(3));
    check("rd_strobes", 64'({sr, sw}), 64'(2'b10));
    check("rd_data", 64'(done_rdata), 64'(8'hA5));
    rdata_en = 1'b0;
    do_cycle(1'b0, 16'h9880, 8'h00, t, sr, sw);
    check("rd_float", 64'(done_rdata), 64'(8'hFF));

    // /WAIT held low for 4 ticks in T2
    rdata = 8'h3C; rdata_en = 1'b1;
    fork
      do_cycle(1'b0, 16'h9881, 8'h00, t, sr, sw);
      begin
        for (int i = 0; i < 1000 && n_trd; i++) @(negedge clk);
        n_wait = 1'b0;
        k = 0;
        for (int i = 0; i < 1000 && k < 4; i++) begin
          if (!mclk_pcen_n) k++;
          @(negedge clk);
        end
        n_wait = 1'b1;
      end
    join
    check("wait_ticks", 64'(t), 64'(7));
    check("wait_data", 64'(done_rdata), 64'(8'h3C));

    // Ticks stuck high mid-cycle: the strobe holds
    fork
      do_cycle(1'b1, 16'h4000, 8'h11, t, sr, sw);
      begin
        for (int i = 0; i < 1000 && n_tsltsl; i++) @(negedge clk);
        tick_mode = 2;
        repeat (50) @(negedge clk);
        check("stall_hold", 64'({n_tsltsl, n_twr, busy}), 64'(3'b001));
        tick_mode = 0;
      end
    join
    check("stall_ticks", 64'(t), 64'(3));

    // req during busy and held through done: back-to-back
    @(negedge clk);
    req_wr = 1'b0; req_addr = 16'h1234; rdata = 8'h77; rdata_en = 1'b1; req = 1'b1;
    acks = 0; got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (ack) acks++;
      if (done) got = 1'b1;
    end
    check("b2b_single_ack", 64'(acks), 64'(1));
    @(negedge clk);
    check("b2b_ack_after_done", 64'(ack), 64'(1));
    g = 0;
    for (int i = 0; i < 500 && n_tsltsl; i++) begin
      if (!mclk_pcen_n) g++;
      @(negedge clk);
    end
    check("b2b_gap_ticks", 64'(g), 64'(1));
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    req = 1'b0;
    check("b2b_second_done", 64'({got, done_rdata}), 64'({1'b1, 8'h77}));

    // Reset during TW
    @(negedge clk);
    req_wr = 1'b0; req_addr = 16'h2222; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 1000 && n_trd; i++) @(negedge clk);
    k = 0;
    for (int i = 0; i < 1000 && k < 1; i++) begin
      if (!mclk_pcen_n) k++;
      @(negedge clk);
    end
    n_reset = 1'b0;
    @(negedge clk);
    check("abort_state", 64'({n_tsltsl, n_trd, n_twr, busy, done}), 64'(5'b11100));
    n_reset = 1'b1;
    do_cycle(1'b1, 16'h9800, 8'hC3, t, sr, sw);
    check("after_abort_ticks", 64'(t), 64'(3));

    // Randomized traffic
    tick_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req       = ($urandom_range(0, 3) == 0);
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      rdata     = 8'($urandom);
      rdata_en  = 1'($urandom_range(0, 1));
      n_wait    = ($urandom_range(0, 3) != 0);
      n_reset   = ($urandom_range(0, 199) != 0);
    end
    req = 1'b0; n_reset = 1'b1; n_wait = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
